// File: rtl/togdec_pkg.sv
// Shared types and default parameter values for the toggle decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package togdec_pkg;

  // Capture FSM: COUNT accumulates a window; HOLD presents a captured count.
  typedef enum logic {
    COUNT = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_LEN    = 2;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/togdec_sync.sv
// Multi-flop synchronizer that brings tog_in into the clk domain.
// Latency: SYNC_STAGES cycles from d to q.
// Backpressure: none; samples every cycle.
module togdec_sync #(
  parameter int SYNC_STAGES = togdec_pkg::DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous level through the flop chain; reset clears every stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_decoder.sv
// Decodes a T-flop toggle line into one-cycle pulses, counts them, and hands out captured counts.
// Latency: pulse_out SYNC_STAGES+FILT_LEN edges after tog_in changes (SYNC_STAGES+1 without the filter).
// Backpressure: a captured count holds on cnt_valid/cnt_data until cnt_ready; counting continues meanwhile.
// Optional glitch filter enabled by defining TOGDEC_GLITCH_FILT_EN.
module toggle_decoder
  import togdec_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN    = DEF_FILT_LEN,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tog_in,
  input  logic             snap,
  input  logic             cnt_ready,
  output logic             q,
  output logic             qbar,
  output logic             pulse_out,
  output logic             cnt_valid,
  output logic [CNT_W-1:0] cnt_data,
  output logic             ovf
);

  // Elaboration-time parameter range guards.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("toggle_decoder: SYNC_STAGES must be 2..4");
  end
  if (FILT_LEN < 1 || FILT_LEN > 8) begin : g_bad_filt
    $error("toggle_decoder: FILT_LEN must be 1..8");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("toggle_decoder: CNT_W must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic sync_lvl;

  togdec_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (tog_in),
    .q    (sync_lvl)
  );

`ifdef TOGDEC_GLITCH_FILT_EN
  // Holds up to FILT_LEN (max 8) consecutive differing samples.
  logic [3:0] filt_cnt;

  // Accept a new level only after FILT_LEN consecutive differing samples; any match restarts the run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_cnt  <= '0;
      q         <= 1'b0;
      pulse_out <= 1'b0;
    end else if (sync_lvl != q) begin
      if (filt_cnt == 4'(FILT_LEN - 1)) begin
        filt_cnt  <= '0;
        q         <= ~q;
        pulse_out <= 1'b1;
      end else begin
        filt_cnt  <= filt_cnt + 4'd1;
        pulse_out <= 1'b0;
      end
    end else begin
      filt_cnt  <= '0;
      pulse_out <= 1'b0;
    end
  end
`else
  // Unfiltered: follow the synchronized level one edge later, strobing on every change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q         <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      q         <= sync_lvl;
      pulse_out <= sync_lvl ^ q;
    end
  end
`endif

  assign qbar = ~q;

  // Event counter next value: add this cycle's pulse, saturating at all-ones.
  logic [CNT_W-1:0] cnt;
  logic             at_max;
  logic             sat_hit;
  logic [CNT_W-1:0] cnt_inc;

  assign at_max  = (cnt == CNT_MAX);
  assign sat_hit = pulse_out && at_max;
  assign cnt_inc = (pulse_out && !at_max) ? cnt + CNT_W'(1) : cnt;

  state_t state;

  // Capture FSM: snap in COUNT captures (including a same-cycle pulse) and opens a new window at 0;
  // HOLD keeps the capture steady and keeps counting until the consumer accepts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= COUNT;
      cnt       <= '0;
      cnt_valid <= 1'b0;
      cnt_data  <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        COUNT: begin
          if (snap) begin
            cnt_data  <= cnt_inc;
            cnt       <= '0;
            cnt_valid <= 1'b1;
            state     <= HOLD;
            // A capture that carries the saturated value reports it, so the sticky flag can clear.
            if (cnt_inc == CNT_MAX) begin
              ovf <= 1'b0;
            end
          end else begin
            cnt <= cnt_inc;
            if (sat_hit) begin
              ovf <= 1'b1;
            end
          end
        end
        HOLD: begin
          cnt <= cnt_inc;
          if (sat_hit) begin
            ovf <= 1'b1;
          end
          if (cnt_valid && cnt_ready) begin
            cnt_valid <= 1'b0;
            state     <= COUNT;
          end
        end
        default: begin
          state <= COUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_decoder.sv
// Self-checking bench for toggle_decoder: scoreboard queue of expected captured counts.
// Latency: n/a.
// Backpressure: drives cnt_ready directly to exercise HOLD.
module tb_toggle_decoder;

  localparam int SYNC  = 2;
  localparam int FILT  = 2;
  localparam int SAT_W = 4;
`ifdef TOGDEC_GLITCH_FILT_EN
  localparam int LAT = SYNC + FILT;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tog_in, snap, cnt_ready;
  logic       q, qbar, pulse_out, cnt_valid, ovf;
  logic [7:0] cnt_data;

  logic             s_tog, s_snap, s_ready;
  logic             s_q, s_qbar, s_pulse, s_valid, s_ovf;
  logic [SAT_W-1:0] s_data;

  int   errors = 0;
  int   checks = 0;
  int   exp_q[$];
  int   exp_win = 0;
  logic tog_lvl = 1'b0;
  logic s_lvl = 1'b0;

  always #5 clk = ~clk;

  toggle_decoder #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .tog_in(tog_in), .snap(snap), .cnt_ready(cnt_ready),
    .q(q), .qbar(qbar), .pulse_out(pulse_out), .cnt_valid(cnt_valid),
    .cnt_data(cnt_data), .ovf(ovf)
  );

  toggle_decoder #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .reset(reset), .tog_in(s_tog), .snap(s_snap), .cnt_ready(s_ready),
    .q(s_q), .qbar(s_qbar), .pulse_out(s_pulse), .cnt_valid(s_valid),
    .cnt_data(s_data), .ovf(s_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle_main();
    tog_lvl = ~tog_lvl;
    tog_in  = tog_lvl;
    exp_win++;
    repeat (8) tick();
  endtask

  task automatic toggle_sat();
    s_lvl = ~s_lvl;
    s_tog = s_lvl;
    repeat (8) tick();
  endtask

  task automatic pulse_snap();
    exp_q.push_back(exp_win);
    exp_win = 0;
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic handshake();
    cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; tog_in = 1'b0; snap = 1'b0; cnt_ready = 1'b0;
    s_tog = 1'b0; s_snap = 1'b0; s_ready = 1'b0;
    #1;
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL reset_q: got %b want 0", q); end
    checks++; if (qbar !== 1'b1) begin errors++; $display("FAIL reset_qbar: got %b want 1", qbar); end
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", pulse_out); end
    checks++; if (cnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", cnt_valid); end
    checks++; if (cnt_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", cnt_data); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_glitch();
    int   first_k = 0;
    int   npulse = 0;
    logic q_first = 1'b0;
    logic q_hi = 1'b0;
    tog_in = 1'b1;
    tick();
    tog_in = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (pulse_out === 1'b1) begin
        npulse++;
        if (first_k == 0) begin first_k = k; q_first = q; end
      end
      if (q === 1'b1) q_hi = 1'b1;
    end
`ifdef TOGDEC_GLITCH_FILT_EN
    checks++; if (npulse != 0) begin errors++; $display("FAIL glitch_pulses: got %0d want 0", npulse); end
    checks++; if (q_hi !== 1'b0) begin errors++; $display("FAIL glitch_q: q rose to %b want stay 0", q_hi); end
`else
    // Unfiltered: the glitch decodes; its return to low is a second toggle that decodes too.
    checks++; if (first_k != LAT) begin errors++; $display("FAIL glitch_latency: got %0d want %0d", first_k, LAT); end
    checks++; if (q_first !== 1'b1) begin errors++; $display("FAIL glitch_q: got %b want 1", q_first); end
    exp_win += 2;
`endif
  endtask

  task automatic test_basic_toggle();
    int first_k = 0;
    int npulse = 0;
    tog_lvl = 1'b1;
    tog_in  = 1'b1;
    exp_win++;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (pulse_out === 1'b1) begin
        npulse++;
        if (first_k == 0) first_k = k;
      end
    end
    checks++; if (first_k != LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", first_k, LAT); end
    checks++; if (npulse != 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", npulse); end
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL basic_q: got %b want 1", q); end
    checks++; if (qbar !== 1'b0) begin errors++; $display("FAIL basic_qbar: got %b want 0", qbar); end
  endtask

  task automatic test_capture();
    int   exp;
    logic stable = 1'b1;
    // Flush whatever the earlier tests accumulated.
    pulse_snap();
    exp = exp_q.pop_front();
    checks++; if (cnt_valid !== 1'b1 || cnt_data !== 8'(exp)) begin errors++;
      $display("FAIL flush_capture: got valid=%b data=%0d want valid=1 data=%0d", cnt_valid, cnt_data, exp); end
    handshake();
    repeat (5) toggle_main();
    pulse_snap();
    exp = exp_q.pop_front();
    checks++; if (cnt_valid !== 1'b1 || cnt_data !== 8'(exp)) begin errors++;
      $display("FAIL capture5: got valid=%b data=%0d want valid=1 data=%0d", cnt_valid, cnt_data, exp); end
    // Held in HOLD with three more toggles and a stray snap; capture must not move.
    for (int c = 0; c < 24; c++) begin
      if (c % 8 == 0) begin tog_lvl = ~tog_lvl; tog_in = tog_lvl; exp_win++; end
      snap = (c == 4);
      tick();
      if (cnt_valid !== 1'b1 || cnt_data !== 8'(exp)) stable = 1'b0;
    end
    snap = 1'b0;
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL hold_stable: got data=%0d valid=%b want data=%0d valid=1", cnt_data, cnt_valid, exp); end
    // Snap together with ready in HOLD completes the handshake only.
    cnt_ready = 1'b1; snap = 1'b1;
    tick();
    cnt_ready = 1'b0; snap = 1'b0;
    checks++; if (cnt_valid !== 1'b0) begin errors++; $display("FAIL handshake_drop: got %b want 0", cnt_valid); end
    tick();
    checks++; if (cnt_valid !== 1'b0) begin errors++; $display("FAIL no_recapture: got %b want 0", cnt_valid); end
    pulse_snap();
    exp = exp_q.pop_front();
    checks++; if (cnt_valid !== 1'b1 || cnt_data !== 8'(exp)) begin errors++;
      $display("FAIL capture3: got valid=%b data=%0d want valid=1 data=%0d", cnt_valid, cnt_data, exp); end
    handshake();
  endtask

  task automatic test_coincidence();
    int exp;
    repeat (6) toggle_main();
    tog_lvl = ~tog_lvl;
    tog_in  = tog_lvl;
    exp_win++;
    repeat (LAT) tick();
    checks++; if (pulse_out !== 1'b1) begin errors++; $display("FAIL coinc_pulse: got %b want 1", pulse_out); end
    pulse_snap();
    exp = exp_q.pop_front();
    checks++; if (cnt_valid !== 1'b1 || cnt_data !== 8'(exp)) begin errors++;
      $display("FAIL coinc_capture: got valid=%b data=%0d want valid=1 data=%0d", cnt_valid, cnt_data, exp); end
    repeat (4) tick();
    handshake();
    pulse_snap();
    exp = exp_q.pop_front();
    checks++; if (cnt_valid !== 1'b1 || cnt_data !== 8'(exp)) begin errors++;
      $display("FAIL coinc_new_window: got valid=%b data=%0d want valid=1 data=%0d", cnt_valid, cnt_data, exp); end
    handshake();
  endtask

  task automatic test_reset_hold();
    int   exp;
    logic phantom = 1'b0;
    toggle_main();
    pulse_snap();
    exp = exp_q.pop_front();
    checks++; if (cnt_valid !== 1'b1 || cnt_data !== 8'(exp)) begin errors++;
      $display("FAIL prereset_capture: got valid=%b data=%0d want valid=1 data=%0d", cnt_valid, cnt_data, exp); end
    reset = 1'b0;
    tog_lvl = 1'b0; tog_in = 1'b0; exp_win = 0;
    #1;
    checks++; if ({q, qbar, pulse_out, cnt_valid, ovf} !== 5'b01000 || cnt_data !== 8'd0) begin errors++;
      $display("FAIL reset_in_hold: got q=%b qbar=%b pulse=%b valid=%b ovf=%b data=%0d want 0 1 0 0 0 0",
               q, qbar, pulse_out, cnt_valid, ovf, cnt_data); end
    repeat (2) tick();
    reset = 1'b1;
    cnt_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (cnt_valid !== 1'b0) phantom = 1'b1;
    end
    cnt_ready = 1'b0;
    checks++; if (phantom !== 1'b0) begin errors++; $display("FAIL reset_pending: cnt_valid=%b want 0", cnt_valid); end
    toggle_main();
    pulse_snap();
    exp = exp_q.pop_front();
    checks++; if (cnt_valid !== 1'b1 || cnt_data !== 8'(exp)) begin errors++;
      $display("FAIL postreset_capture: got valid=%b data=%0d want valid=1 data=%0d", cnt_valid, cnt_data, exp); end
    handshake();
  endtask

  task automatic test_saturation();
    int n = 17;
    int sat_max = (1 << SAT_W) - 1;
    int exp;
    for (int i = 0; i < n; i++) toggle_sat();
    exp_q.push_back((n > sat_max) ? sat_max : n);
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", s_ovf); end
    checks++; if (s_q !== 1'b1) begin errors++; $display("FAIL sat_q: got %b want 1", s_q); end
    s_snap = 1'b1;
    tick();
    s_snap = 1'b0;
    exp = exp_q.pop_front();
    checks++; if (s_valid !== 1'b1 || s_data !== SAT_W'(exp)) begin errors++;
      $display("FAIL sat_capture: got valid=%b data=%0d want valid=1 data=%0d", s_valid, s_data, exp); end
    checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_clear: got %b want 0", s_ovf); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_basic_toggle();
    test_capture();
    test_coincidence();
    test_reset_hold();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
